ex_div_unit: RTL and testbench
==============================

Name: ex_div_unit

Overview:
- Iterative RV32M divider in the EX stage, fed by the forwarded operands from the EX operand-forwarding mux.
- Executes DIV, DIVU, REM and REMU using radix-2 restoring division, producing one quotient bit per cycle.
- Holds busy_o high while an operation is in flight; the hazard unit uses it to stall IF/ID/EX.
- Pulses valid_o with the result, which is then handed to the EX/MEM register.

Parameters:
- XLEN, 32, operand and result width. Only 32 is supported; the iteration counter is $clog2(XLEN) bits wide.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  launch request. Sampled only in IDLE.
- op_i  in  2  core::div_op_t encoding: DIV=0, DIVU=1, REM=2, REMU=3
- rs1_i  in  XLEN  dividend, already forwarded
- rs2_i  in  XLEN  divisor, already forwarded
- flush_i  in  1  pipeline flush from branch or exception. Aborts the operation.
- busy_o  out  1  operation in flight; the stall request
- valid_o  out  1  single-cycle pulse, result_o is valid
- result_o  out  XLEN  quotient or remainder. Held until the next accepted start.

Behaviour:
- Reset (async, rst_ni=0):
  - state goes to IDLE.
  - busy_o=0, valid_o=0, result_o=0.
  - All internal registers are cleared.
  - Reset asserted mid-operation discards the operation; no valid_o follows.
- States (core::div_state_t): IDLE, CALC, FIX, DONE.
- IDLE:
  - When start_i=1 and flush_i=0 at an edge in cycle T, latch op_i, the operand signs and the operand magnitudes. Signed ops use absolute values; unsigned ops use raw values.
  - If rs2_i==0, go to DONE with the fast-path result:
    - DIV/DIVU: 0xFFFFFFFF.
    - REM/REMU: rs1_i unchanged.
  - If op=DIV or REM, rs1_i==0x80000000 and rs2_i==0xFFFFFFFF (overflow), go to DONE with the fast-path result:
    - DIV: 0x80000000.
    - REM: 0.
  - Otherwise go to CALC, clear the remainder and set count=0.
  - start_i in any state other than IDLE is ignored.
- CALC:
  - Each cycle: shift {rem, quo} left by 1, bringing in the dividend MSB.
  - If rem >= divisor, subtract the divisor and set the quotient LSB.
  - Increment count; when count==XLEN-1, go to FIX next.
  - Runs exactly 32 cycles, T+1..T+32.
- FIX (cycle T+33):
  - Signed-op correction. The quotient is negated if the operand signs differ.
  - The remainder takes the sign of the dividend.
  - Register the selected value into result_o.
- DONE (cycle T+34 normal, T+1 fast path):
  - valid_o=1 for exactly this cycle.
  - Next state is IDLE, so back-to-back starts are possible from T+35.
- busy_o:
  - Equals (state==CALC || state==FIX) || (state==IDLE && start accepted this cycle). It is combinational so the stall takes effect in cycle T.
  - busy_o is 0 in DONE, which lets the pipeline advance in the same cycle valid_o is high.
- flush_i:
  - In CALC or FIX, next state is IDLE; no valid_o.
  - In DONE, valid_o is still output this cycle; the consumer discards it.
  - flush_i and start_i together in IDLE: start is not accepted.
- result_o: updated only on entry to DONE and held otherwise.
- Arithmetic: the remainder register is XLEN+1 bits so the compare/subtract happens without overflow. Negation is two's complement.

Decomposition:
- core package gains:
  - typedef enum logic [1:0] div_op_t {DIV, DIVU, REM, REMU}
  - typedef enum logic [1:0] div_state_t {IDLE, CALC, FIX, DONE}
  - localparam DIV_LATENCY=34
- No sub-module: the single FSM, datapath and counter sit in one file. An optional abs/negate helper function goes in the core package.

Test Plan:
- DIVU, rs1=100, rs2=7, start at T -> busy_o=1 during T..T+33, valid_o=1 at T+34, result_o=14. Repeat with REMU -> 2.
- DIV, rs1=0xFFFFFFF9 (-7), rs2=2 -> result_o=0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1). Both at T+34.
- DIV and REM by zero, rs1=0x12345678, rs2=0 -> valid_o at T+1. DIV gives 0xFFFFFFFF; REM gives 0x12345678.
- DIV overflow, rs1=0x80000000, rs2=0xFFFFFFFF -> valid_o at T+1, result_o=0x80000000. REM with the same operands -> 0.
- Flush mid-operation:
  - Start DIVU at T, flush_i=1 at T+10 -> no valid_o, busy_o=0 from T+11.
  - New start DIVU 9/3 at T+11 -> result_o=3 at T+45.
- Reset mid-operation:
  - rst_ni=0 at T+5 -> immediately busy_o=0, valid_o=0, result_o=0.
  - After release, start_i held high during CALC is ignored (no second launch).

Source files
------------

// File: rtl/ex_div_unit_pkg.sv
// Shared types and helpers for the EX-stage iterative divider.
package ex_div_unit_pkg;

  localparam int unsigned DIV_LATENCY = 34;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  // Magnitude of a two's complement value; 0x80000000 maps to itself, which is
  // the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? neg32(x) : x;
  endfunction

endpackage

// File: rtl/ex_div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
module ex_div_unit
  import ex_div_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  div_op_t         op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CW = $clog2(XLEN);

  div_state_t      state_q, state_d;
  div_op_t         op_q;
  logic [CW-1:0]   count_q;
  logic            sign1_q, sign2_q;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;

  logic            accept;
  logic            in_signed, in_rem;
  logic            div_zero, overflow, fast;
  logic [XLEN-1:0] fast_res;
  logic [XLEN:0]   rem_sh, rem_sub;
  logic            ge;
  logic            op_signed_q, op_rem_q;
  logic [XLEN-1:0] q_fix, r_fix, fix_res;

  always_comb begin
    accept    = (state_q == IDLE) && start_i && !flush_i;
    in_signed = (op_i == DIV) || (op_i == REM);
    in_rem    = (op_i == REM) || (op_i == REMU);
    div_zero  = (rs2_i == '0);
    overflow  = in_signed && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
    fast      = div_zero || overflow;
    // Overflow dividend is 0x80000000, so DIV returns rs1 unchanged.
    if (div_zero) fast_res = in_rem ? rs1_i : '1;
    else          fast_res = in_rem ? '0 : rs1_i;
  end

  always_comb begin
    rem_sh  = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    ge      = (rem_sh >= {1'b0, dvs_q});
    rem_sub = rem_sh - {1'b0, dvs_q};
  end

  always_comb begin
    op_signed_q = (op_q == DIV) || (op_q == REM);
    op_rem_q    = (op_q == REM) || (op_q == REMU);
    q_fix = (op_signed_q && (sign1_q ^ sign2_q)) ? neg32(quo_q) : quo_q;
    r_fix = (op_signed_q && sign1_q) ? neg32(rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];
    fix_res = op_rem_q ? r_fix : q_fix;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          busy_o  = 1'b1;
          state_d = fast ? DONE : CALC;
        end
      end
      CALC: begin
        busy_o = 1'b1;
        if (flush_i)                           state_d = IDLE;
        else if (count_q == CW'(XLEN - 1))     state_d = FIX;
      end
      FIX: begin
        busy_o  = 1'b1;
        state_d = flush_i ? IDLE : DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q     <= DIV;
      count_q  <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_o <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_q    <= op_i;
            sign1_q <= rs1_i[XLEN-1];
            sign2_q <= rs2_i[XLEN-1];
            quo_q   <= in_signed ? abs32(rs1_i) : rs1_i;
            dvs_q   <= in_signed ? abs32(rs2_i) : rs2_i;
            rem_q   <= '0;
            count_q <= '0;
            if (fast) result_o <= fast_res;
          end
        end
        CALC: begin
          rem_q   <= ge ? rem_sub : rem_sh;
          quo_q   <= {quo_q[XLEN-2:0], ge};
          count_q <= count_q + 1'b1;
        end
        FIX: begin
          if (!flush_i) result_o <= fix_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// Scoreboard bench for ex_div_unit: directed vectors, latency and busy/valid checks.
module tb_ex_div_unit;
  import ex_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  div_op_t     op = DIVU;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        flush = 1'b0;
  logic        busy, valid;
  logic [31:0] result;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    string       nm;
    logic [31:0] res;
    int unsigned due;
  } exp_t;
  exp_t sb[$];

  ex_div_unit #(.XLEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op),
    .rs1_i(rs1), .rs2_i(rs2), .flush_i(flush),
    .busy_o(busy), .valid_o(valid), .result_o(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the head of the scoreboard, on the due cycle.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid cycle=%0d actual=%h expected=none", cyc, result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (result !== e.res || cyc != e.due) begin
          errors++;
          $display("FAIL %s actual=%h@%0d expected=%h@%0d", e.nm, result, cyc, e.res, e.due);
        end
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_in_done cycle=%0d actual=%b expected=0", cyc, busy);
      end
    end
  end

  task automatic drain(input int unsigned bound);
    for (int unsigned k = 0; k < bound && sb.size() != 0; k++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL timeout cycle=%0d actual=%0d_pending expected=0", cyc, sb.size());
      sb.delete();
    end
  endtask

  task automatic run_op(input string nm, input div_op_t o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int unsigned lat);
    exp_t e;
    @(posedge clk); #1;
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    e.nm = nm; e.res = exp; e.due = cyc + lat;
    sb.push_back(e);
    #1 check({nm, "_busy_T"}, {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    for (int unsigned i = 1; i < lat; i++) begin
      check({nm, "_busy_hold"}, {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    drain(8);
  endtask

  initial begin
    int unsigned t0;
    exp_t e;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_valid", {31'b0, valid}, 32'd0);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;

    run_op("divu_100_7",  DIVU, 32'd100,       32'd7,          32'd14,         34);
    run_op("remu_100_7",  REMU, 32'd100,       32'd7,          32'd2,          34);
    run_op("div_m7_2",    DIV,  32'hFFFFFFF9,  32'd2,          32'hFFFFFFFD,   34);
    run_op("rem_m7_2",    REM,  32'hFFFFFFF9,  32'd2,          32'hFFFFFFFF,   34);
    run_op("div_by0",     DIV,  32'h12345678,  32'd0,          32'hFFFFFFFF,   1);
    run_op("rem_by0",     REM,  32'h12345678,  32'd0,          32'h12345678,   1);
    run_op("divu_by0",    DIVU, 32'hDEADBEEF,  32'd0,          32'hFFFFFFFF,   1);
    run_op("remu_by0",    REMU, 32'd5,         32'd0,          32'd5,          1);
    run_op("div_ovf",     DIV,  32'h80000000,  32'hFFFFFFFF,   32'h80000000,   1);
    run_op("rem_ovf",     REM,  32'h80000000,  32'hFFFFFFFF,   32'd0,          1);
    run_op("divu_nonovf", DIVU, 32'h80000000,  32'hFFFFFFFF,   32'd0,          34);
    run_op("remu_nonovf", REMU, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,   34);
    run_op("div_7_m2",    DIV,  32'd7,         32'hFFFFFFFE,   32'hFFFFFFFD,   34);
    run_op("rem_7_m2",    REM,  32'd7,         32'hFFFFFFFE,   32'd1,          34);
    run_op("div_m7_m2",   DIV,  32'hFFFFFFF9,  32'hFFFFFFFE,   32'd3,          34);
    run_op("rem_m7_m2",   REM,  32'hFFFFFFF9,  32'hFFFFFFFE,   32'hFFFFFFFF,   34);
    run_op("div_min_2",   DIV,  32'h80000000,  32'd2,          32'hC0000000,   34);
    run_op("divu_max_1",  DIVU, 32'hFFFFFFFF,  32'd1,          32'hFFFFFFFF,   34);
    run_op("divu_5_10",   DIVU, 32'd5,         32'd10,         32'd0,          34);
    run_op("remu_5_10",   REMU, 32'd5,         32'd10,         32'd5,          34);

    // start together with flush in IDLE is not accepted
    @(posedge clk); #1;
    op = DIVU; rs1 = 32'd50; rs2 = 32'd5; start = 1'b1; flush = 1'b1;
    #1 check("start_flush_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("start_flush_idle", {31'b0, busy}, 32'd0);
    repeat (40) @(posedge clk);

    // flush mid-operation, then relaunch at T+11
    #1;
    t0 = cyc;
    op = DIVU; rs1 = 32'd1000; rs2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < t0 + 10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy_T11", {31'b0, busy}, 32'd0);
    op = DIVU; rs1 = 32'd9; rs2 = 32'd3; start = 1'b1;
    e.nm = "divu_9_3_after_flush"; e.res = 32'd3; e.due = t0 + 45;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    drain(60);

    // reset mid-operation
    @(posedge clk); #1;
    t0 = cyc;
    op = DIVU; rs1 = 32'd77; rs2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < t0 + 5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_valid", {31'b0, valid}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // start held high through CALC must not relaunch
    @(posedge clk); #1;
    op = DIVU; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    e.nm = "divu_held_start"; e.res = 32'd14; e.due = cyc + 34;
    sb.push_back(e);
    repeat (20) begin @(posedge clk); #1; end
    check("held_start_busy", {31'b0, busy}, 32'd1);
    start = 1'b0;
    drain(40);
    repeat (40) @(posedge clk);
    #1;
    check("held_start_idle", {31'b0, busy}, 32'd0);
    check("result_held", result, 32'd14);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty actual=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
